// File: rtl/aux_rail_seq_pkg.sv
// Purpose : shared state encoding and helpers for the standby-rail sequencer.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aux_rail_seq_pkg;

    localparam int STATE_W   = 3;
    localparam int MAX_RAILS = 8;

    // Encoding is also what ovState presents to Mstr_Seq, so values are fixed.
    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        REQ_DLY  = 3'd1,
        RAIL_ON  = 3'd2,
        RST_DLY  = 3'd3,
        DONE     = 3'd4,
        RAIL_OFF = 3'd5,
        FAULT    = 3'd6
    } seqState_t;

    // Thermometer mask with bits [idx:0] set.
    function automatic logic [MAX_RAILS-1:0] railMask(input logic [2:0] idx);
        logic [MAX_RAILS:0] wide;
        wide = (9'd2 << idx) - 9'd1;
        return wide[MAX_RAILS-1:0];
    endfunction

endpackage

// File: rtl/aux_rail_seq_ms.sv
// Purpose : millisecond timer, synchronous clear, counts i1mSCE pulses, saturates at all-ones.
// Latency : count registered; oHit is a combinational compare of the registered count.
// Backpressure: none; ports iClk, iRst, iClr, i1mSCE, iCmp in; oHit out.
module ms_timer #(
    parameter int CNT_BITS = 6
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClr,
    input  logic                i1mSCE,
    input  logic [CNT_BITS-1:0] iCmp,
    output logic                oHit
);

    logic [CNT_BITS-1:0] cnt;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            cnt <= '0;
        else if (iClr)
            cnt <= '0;
        else if (i1mSCE && (cnt != '1))
            cnt <= cnt + CNT_BITS'(1);
    end

    assign oHit = (cnt == iCmp);

endmodule

// File: rtl/aux_rail_seq.sv
// Purpose : standby-rail sequencer; ascending power-up with PWRGD timeout, reverse power-down, fault latch.
// Latency : every output registered, updates on the same edge as the state/index it reflects.
// Backpressure: none; iPwrReq/ivPwrgd/iRstHold_n/iGoOutFltSt/i1mSCE in, ovEn/oRst_n/oPwrgd/oPwrFlt/ovFltRail/ovState out.
module aux_rail_seq
    import aux_rail_seq_pkg::*;
#(
    parameter int NUM_RAILS  = 3,
    parameter int CNT_BITS   = 6,
    parameter int REQ_DLY_MS = 1,
    parameter int PGD_TMO_MS = 20,
    parameter int RST_DLY_MS = 2,
    parameter int OFF_DLY_MS = 1
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 i1mSCE,
    input  logic                 iPwrReq,
    input  logic                 iRstHold_n,
    input  logic                 iGoOutFltSt,
    input  logic [NUM_RAILS-1:0] ivPwrgd,
    output logic [NUM_RAILS-1:0] ovEn,
    output logic                 oRst_n,
    output logic                 oPwrgd,
    output logic                 oPwrFlt,
    output logic [NUM_RAILS-1:0] ovFltRail,
    output logic [STATE_W-1:0]   ovState
);

    localparam int IDX_W   = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam int CNT_MAX = (1 << CNT_BITS) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    if (NUM_RAILS < 1 || NUM_RAILS > MAX_RAILS) begin : gBadRails
        $error("aux_rail_seq: NUM_RAILS must be 1..8");
    end
    if (REQ_DLY_MS > CNT_MAX || PGD_TMO_MS > CNT_MAX ||
        RST_DLY_MS > CNT_MAX || OFF_DLY_MS > CNT_MAX) begin : gBadDly
        $error("aux_rail_seq: delay parameter exceeds timer range");
    end

    seqState_t             state, nextState;
    logic [IDX_W-1:0]      idx, nextIdx;
    logic                  tmrClr, tmrHit;
    logic [CNT_BITS-1:0]   tmrCmp;
    logic [NUM_RAILS-1:0]  lowerMask, nextMask;

    // Rails below the current index must already be good while ramping.
    assign lowerMask = NUM_RAILS'(railMask(3'(idx)) >> 1);
    assign nextMask  = NUM_RAILS'(railMask(3'(nextIdx)));

    always_comb begin
        tmrCmp = '1;
        case (state)
            REQ_DLY:  tmrCmp = CNT_BITS'(REQ_DLY_MS);
            RAIL_ON:  tmrCmp = CNT_BITS'(PGD_TMO_MS);
            RST_DLY:  tmrCmp = CNT_BITS'(RST_DLY_MS);
            RAIL_OFF: tmrCmp = CNT_BITS'(OFF_DLY_MS);
            default:  tmrCmp = '1;
        endcase
    end

    // Branch order encodes the tie-breaks: power-down beats a PWRGD loss,
    // and the current rail's PWRGD beats its own timeout.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        case (state)
            IDLE: if (iPwrReq) nextState = REQ_DLY;
            REQ_DLY: begin
                if (!iPwrReq)
                    nextState = IDLE;
                else if (tmrHit) begin
                    nextState = RAIL_ON;
                    nextIdx   = '0;
                end
            end
            RAIL_ON: begin
                if (!iPwrReq)
                    nextState = RAIL_OFF;
                else if ((~ivPwrgd & lowerMask) != '0)
                    nextState = FAULT;
                else if (ivPwrgd[idx]) begin
                    if (idx == LAST_IDX)
                        nextState = RST_DLY;
                    else
                        nextIdx = idx + IDX_W'(1);
                end else if (tmrHit)
                    nextState = FAULT;
            end
            RST_DLY: begin
                if (!iPwrReq)           nextState = RAIL_OFF;
                else if (!(&ivPwrgd))   nextState = FAULT;
                else if (tmrHit)        nextState = DONE;
            end
            DONE: begin
                if (!iPwrReq)           nextState = RAIL_OFF;
                else if (!(&ivPwrgd))   nextState = FAULT;
            end
            RAIL_OFF: begin
                if (tmrHit) begin
                    if (idx == '0)
                        nextState = IDLE;
                    else
                        nextIdx = idx - IDX_W'(1);
                end
            end
            FAULT: if (iGoOutFltSt) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Every state entry and every rail step restarts the ms timer.
    assign tmrClr = (nextState != state) || (nextIdx != idx);

    ms_timer #(.CNT_BITS(CNT_BITS)) uTimer (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClr   (tmrClr),
        .i1mSCE (i1mSCE),
        .iCmp   (tmrCmp),
        .oHit   (tmrHit)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            idx       <= '0;
            ovEn      <= '0;
            oRst_n    <= 1'b0;
            oPwrgd    <= 1'b0;
            oPwrFlt   <= 1'b0;
            ovFltRail <= '0;
        end else begin
            state   <= nextState;
            idx     <= nextIdx;
            oPwrgd  <= (nextState == DONE);
            oRst_n  <= (nextState == DONE) && iRstHold_n;
            oPwrFlt <= (nextState == FAULT);
            case (nextState)
                RAIL_ON:       ovEn <= nextMask;
                RST_DLY, DONE: ovEn <= '1;
                // Entry keeps the enables; each step masks off the rail above nextIdx.
                RAIL_OFF:      ovEn <= ovEn & nextMask;
                default:       ovEn <= '0;
            endcase
            if (nextState == FAULT && state != FAULT)
                ovFltRail <= ovEn & ~ivPwrgd;
            else if (nextState != FAULT)
                ovFltRail <= '0;
        end
    end

    assign ovState = state;

endmodule

// File: tb/tb_aux_rail_seq.sv
// Purpose : bench for aux_rail_seq with a behavioural rail model and an output-change scoreboard.
// Latency : a ms is 20 iClk here; rails report PWRGD two ms pulses after their enable.
// Backpressure: n/a.
module tb_aux_rail_seq;
    import aux_rail_seq_pkg::*;

    localparam int NR = 3;
    localparam int MS = 20;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          i1mSCE = 1'b0;
    logic          iPwrReq = 1'b0;
    logic          iRstHold_n = 1'b1;
    logic          iGoOutFltSt = 1'b0;
    logic [NR-1:0] ivPwrgd;
    logic [NR-1:0] ovEn, ovFltRail;
    logic          oRst_n, oPwrgd, oPwrFlt;
    logic [2:0]    ovState;

    logic [NR-1:0] pgModel = '0;
    logic [NR-1:0] forceLow = '0;
    assign ivPwrgd = pgModel & ~forceLow;

    aux_rail_seq #(
        .NUM_RAILS(NR), .CNT_BITS(6), .REQ_DLY_MS(1),
        .PGD_TMO_MS(20), .RST_DLY_MS(2), .OFF_DLY_MS(1)
    ) dut (
        .iClk(iClk), .iRst(iRst), .i1mSCE(i1mSCE), .iPwrReq(iPwrReq),
        .iRstHold_n(iRstHold_n), .iGoOutFltSt(iGoOutFltSt), .ivPwrgd(ivPwrgd),
        .ovEn(ovEn), .oRst_n(oRst_n), .oPwrgd(oPwrgd), .oPwrFlt(oPwrFlt),
        .ovFltRail(ovFltRail), .ovState(ovState)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ceCnt = 0;
    int pgCnt [NR];
    logic [11:0] expQ [$];
    bit monOn = 1'b0;

    wire [11:0] dutSnap = {ovState, ovEn, oRst_n, oPwrgd, oPwrFlt, ovFltRail};

    function automatic logic [11:0] snap(input logic [2:0] st, input logic [2:0] en,
                                         input logic rst, input logic pg, input logic flt,
                                         input logic [2:0] fr);
        return {st, en, rst, pg, flt, fr};
    endfunction

    task automatic push(input logic [2:0] st, input logic [2:0] en, input logic rst,
                        input logic pg, input logic flt, input logic [2:0] fr);
        expQ.push_back(snap(st, en, rst, pg, flt, fr));
    endtask

    // Power-up sequence from IDLE with request high and healthy rails.
    task automatic pushPowerUp();
        push(1, 3'b000, 0, 0, 0, 3'b000);
        push(2, 3'b001, 0, 0, 0, 3'b000);
        push(2, 3'b011, 0, 0, 0, 3'b000);
        push(2, 3'b111, 0, 0, 0, 3'b000);
        push(3, 3'b111, 0, 0, 0, 3'b000);
        push(4, 3'b111, 1, 1, 0, 3'b000);
    endtask

    task automatic pushPowerDown();
        push(5, 3'b111, 0, 0, 0, 3'b000);
        push(5, 3'b011, 0, 0, 0, 3'b000);
        push(5, 3'b001, 0, 0, 0, 3'b000);
        push(0, 3'b000, 0, 0, 0, 3'b000);
    endtask

    task automatic compareSnap(input logic [11:0] got);
        logic [11:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: state=%0d en=%b rst_n=%b pgd=%b flt=%b fltRail=%b, none expected",
                     got[11:9], got[8:6], got[5], got[4], got[3], got[2:0]);
        end else begin
            exp = expQ.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL sb_output: got state=%0d en=%b rst_n=%b pgd=%b flt=%b fltRail=%b, expected state=%0d en=%b rst_n=%b pgd=%b flt=%b fltRail=%b",
                         got[11:9], got[8:6], got[5], got[4], got[3], got[2:0],
                         exp[11:9], exp[8:6], exp[5], exp[4], exp[3], exp[2:0]);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkRange(input string tag, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s: got %0d cycles, expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic waitFail(input string tag, input int budget);
        checks++;
        errors++;
        $display("FAIL wait_%s: condition not reached in %0d cycles", tag, budget);
    endtask

    task automatic waitState(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (ovState !== s && n < budget) begin
            @(negedge iClk);
            n++;
        end
        if (ovState !== s) waitFail(tag, budget);
    endtask

    task automatic waitEn(input logic [2:0] v, input int budget, input string tag);
        int n = 0;
        while (ovEn !== v && n < budget) begin
            @(negedge iClk);
            n++;
        end
        if (ovEn !== v) waitFail(tag, budget);
    endtask

    // ms pulse generator and rail model: PWRGD follows two ms pulses after enable, drops with enable.
    initial begin
        for (int k = 0; k < NR; k++) pgCnt[k] = 0;
        forever begin
            @(negedge iClk);
            cyc++;
            ceCnt  = (ceCnt == MS - 1) ? 0 : ceCnt + 1;
            i1mSCE = (ceCnt == 0);
            for (int k = 0; k < NR; k++) begin
                if (ovEn[k] !== 1'b1) begin
                    pgCnt[k]   = 0;
                    pgModel[k] = 1'b0;
                end else if (!pgModel[k] && i1mSCE) begin
                    pgCnt[k]++;
                    if (pgCnt[k] == 2) pgModel[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: every change of the output tuple is matched against the next expectation.
    initial begin
        logic [11:0] prev;
        wait (monOn);
        @(negedge iClk);
        prev = dutSnap;
        compareSnap(prev);
        forever begin
            @(negedge iClk);
            if (dutSnap !== prev) begin
                prev = dutSnap;
                compareSnap(prev);
            end
        end
    end

    initial begin
        int t0;
        int n;
        #1 iRst = 1'b1;
        repeat (3) @(negedge iClk);
        push(0, 3'b000, 0, 0, 0, 3'b000);
        monOn = 1'b1;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        repeat (2) @(negedge iClk);

        // Normal power-up; reset release 1-2 ms after last PWRGD.
        pushPowerUp();
        iPwrReq = 1'b1;
        n = 0;
        while (ivPwrgd !== 3'b111 && n < 600) begin @(negedge iClk); n++; end
        if (ivPwrgd !== 3'b111) waitFail("all_pgd", 600);
        t0 = cyc;
        n = 0;
        while (oRst_n !== 1'b1 && n < 100) begin @(negedge iClk); n++; end
        if (oRst_n !== 1'b1) waitFail("rst_rel", 100);
        checkRange("rst_dly", cyc - t0, 20, 42);

        // Orderly power-down.
        pushPowerDown();
        @(negedge iClk);
        iPwrReq = 1'b0;
        @(negedge iClk);
        check("pwrdn_first_clk", {29'd0, oRst_n, oPwrgd, 1'b0} | 32'(ovEn) << 3, {29'd0, 3'b000} | 32'(3'b111) << 3);
        waitState(0, 200, "pwrdn_idle");

        // Rail 1 never reports good: timeout fault, then recover.
        push(1, 3'b000, 0, 0, 0, 3'b000);
        push(2, 3'b001, 0, 0, 0, 3'b000);
        push(2, 3'b011, 0, 0, 0, 3'b000);
        push(6, 3'b000, 0, 0, 1, 3'b010);
        forceLow = 3'b010;
        iPwrReq  = 1'b1;
        waitEn(3'b011, 400, "en011");
        t0 = cyc;
        waitState(6, 600, "tmo_fault");
        checkRange("pgd_tmo", cyc - t0, 375, 405);
        push(0, 3'b000, 0, 0, 0, 3'b000);
        pushPowerUp();
        @(negedge iClk);
        forceLow    = '0;
        iGoOutFltSt = 1'b1;
        @(negedge iClk);
        iGoOutFltSt = 1'b0;
        waitState(4, 600, "done_after_tmo");

        // One-cycle PWRGD loss on rail 0 while DONE.
        push(6, 3'b000, 0, 0, 1, 3'b001);
        @(negedge iClk);
        forceLow = 3'b001;
        @(negedge iClk);
        forceLow = '0;
        check("flt_next_clk", {28'd0, oPwrFlt, oRst_n, ovEn}, {28'd0, 1'b1, 1'b0, 3'b000});
        push(0, 3'b000, 0, 0, 0, 3'b000);
        pushPowerUp();
        @(negedge iClk);
        iGoOutFltSt = 1'b1;
        @(negedge iClk);
        iGoOutFltSt = 1'b0;
        waitState(4, 600, "done_after_flt");

        // Reset hold in DONE keeps oPwrgd.
        push(4, 3'b111, 0, 1, 0, 3'b000);
        push(4, 3'b111, 1, 1, 0, 3'b000);
        @(negedge iClk);
        iRstHold_n = 1'b0;
        @(negedge iClk);
        check("rst_hold", {30'd0, oRst_n, oPwrgd}, 32'b01);
        iRstHold_n = 1'b1;
        repeat (2) @(negedge iClk);

        // Request drop and PWRGD loss together: power-down wins.
        pushPowerDown();
        iPwrReq  = 1'b0;
        forceLow = 3'b100;
        @(negedge iClk);
        check("pwrdn_vs_flt", {28'd0, ovState, oPwrFlt}, {28'd0, RAIL_OFF, 1'b0});
        waitState(0, 200, "pwrdn2_idle");
        forceLow = '0;

        // Request glitch with no ms pulse inside it.
        push(1, 3'b000, 0, 0, 0, 3'b000);
        push(0, 3'b000, 0, 0, 0, 3'b000);
        n = 0;
        while (ceCnt != 5 && n < 40) begin @(negedge iClk); n++; end
        iPwrReq = 1'b1;
        repeat (3) @(negedge iClk);
        iPwrReq = 1'b0;
        repeat (30) @(negedge iClk);
        check("glitch_no_en", 32'(ovEn), 32'd0);

        // Asynchronous reset mid ramp.
        push(1, 3'b000, 0, 0, 0, 3'b000);
        push(2, 3'b001, 0, 0, 0, 3'b000);
        push(2, 3'b011, 0, 0, 0, 3'b000);
        push(0, 3'b000, 0, 0, 0, 3'b000);
        iPwrReq = 1'b1;
        waitEn(3'b011, 400, "en011_rst");
        @(negedge iClk);
        #2 iRst = 1'b1;
        #1 check("async_rst", 32'(dutSnap), 32'd0);
        iPwrReq = 1'b0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        repeat (5) @(negedge iClk);

        check("sb_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
